// File: rtl/tmr_replica_monitor.sv
// tmr_replica_monitor: majority voter and fault monitor for three replica words coming from
// a triplicated FSM. It tracks persistent single-replica mismatches and flags multi-faults.
// Optional feature: define TMR_MONITOR_ERRCNT_EN to build the saturating mismatch counter
// (errCnt). Without the macro, errCnt is tied to zero and no counter flops exist.
module tmr_replica_monitor #(
  parameter int unsigned W       = 8,
  parameter int unsigned PERSIST = 3,
  parameter int unsigned CNTW    = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [W-1:0]    inA,
  input  logic [W-1:0]    inB,
  input  logic [W-1:0]    inC,
  input  logic            clr,
  output logic [W-1:0]    out,
  output logic            misA,
  output logic            misB,
  output logic            misC,
  output logic            multi,
  output logic [1:0]      state,
  output logic [1:0]      faultId,
  output logic [CNTW-1:0] errCnt
);

  typedef enum logic [1:0] {
    StOk      = 2'd0,
    StSuspect = 2'd1,
    StFault   = 2'd2
  } state_e;

  // Replica ids: none=0, A=1, B=2, C=3 (3 also denotes multi-fault).
  localparam logic [1:0] IdNone  = 2'd0;
  localparam logic [1:0] IdMulti = 2'd3;

  state_e     r_state, w_state_d;
  logic [3:0] r_pc, w_pc_d;
  logic [1:0] r_sid, w_sid_d;
  logic [1:0] r_fid, w_fid_d;
  logic       r_multi;
  logic [W-1:0] r_out;
  logic       r_mis_a, r_mis_b, r_mis_c;

  logic [W-1:0] w_vote;
  logic       w_mis_a, w_mis_b, w_mis_c;
  logic       w_multi, w_single, w_any;
  logic [1:0] w_id;
  logic [3:0] w_pc_inc;

  // Combinational vote and mismatch classification of the current inputs.
  always_comb begin
    w_vote   = (inA & inB) | (inB & inC) | (inA & inC);
    w_mis_a  = (inA != w_vote);
    w_mis_b  = (inB != w_vote);
    w_mis_c  = (inC != w_vote);
    w_multi  = (inA != inB) && (inB != inC) && (inA != inC);
    w_single = !w_multi && ({w_mis_a, w_mis_b, w_mis_c} inside {3'b100, 3'b010, 3'b001});
    w_any    = w_mis_a | w_mis_b | w_mis_c | w_multi;
    w_pc_inc = r_pc + 4'd1;
    w_id     = IdNone;
    if (w_mis_a)      w_id = 2'd1;
    else if (w_mis_b) w_id = 2'd2;
    else if (w_mis_c) w_id = 2'd3;
  end

  // Voter output and per-replica flags keep updating in every state, even across clr.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out   <= '0;
      r_mis_a <= 1'b0;
      r_mis_b <= 1'b0;
      r_mis_c <= 1'b0;
    end else begin
      r_out   <= w_vote;
      r_mis_a <= w_mis_a;
      r_mis_b <= w_mis_b;
      r_mis_c <= w_mis_c;
    end
  end

  // FSM state register together with its suspect/fault bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= StOk;
      r_pc    <= 4'd0;
      r_sid   <= IdNone;
      r_fid   <= IdNone;
      r_multi <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_sid   <= w_sid_d;
      r_fid   <= w_fid_d;
      r_multi <= clr ? 1'b0 : (r_multi | w_multi);
    end
  end

  // Next-state logic; clr wins over any mismatch seen in the same cycle.
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_sid_d   = r_sid;
    w_fid_d   = r_fid;
    if (clr) begin
      w_state_d = StOk;
      w_pc_d    = 4'd0;
      w_sid_d   = IdNone;
      w_fid_d   = IdNone;
    end else begin
      unique case (r_state)
        StOk: begin
          if (w_multi) begin
            w_state_d = StFault;
            w_fid_d   = IdMulti;
          end else if (w_single) begin
            w_state_d = StSuspect;
            w_sid_d   = w_id;
            w_pc_d    = 4'd1;
          end else begin
            w_pc_d    = 4'd0;
          end
        end
        StSuspect: begin
          if (w_multi) begin
            w_state_d = StFault;
            w_fid_d   = IdMulti;
          end else if (w_single && (w_id == r_sid)) begin
            w_pc_d = w_pc_inc;
            if (w_pc_inc == 4'(PERSIST)) begin
              w_state_d = StFault;
              w_fid_d   = r_sid;
            end
          end else if (w_single) begin
            // A different replica now disagrees: restart persistence tracking on it.
            w_sid_d = w_id;
            w_pc_d  = 4'd1;
          end else begin
            w_state_d = StOk;
            w_pc_d    = 4'd0;
            w_sid_d   = IdNone;
          end
        end
        StFault: begin
          // Fault is latched until clr or reset.
        end
        default: begin
          w_state_d = StOk;
          w_pc_d    = 4'd0;
          w_sid_d   = IdNone;
          w_fid_d   = IdNone;
        end
      endcase
    end
  end

  // Output decode of registered state.
  always_comb begin
    out     = r_out;
    misA    = r_mis_a;
    misB    = r_mis_b;
    misC    = r_mis_c;
    multi   = r_multi;
    state   = r_state;
    faultId = r_fid;
  end

`ifdef TMR_MONITOR_ERRCNT_EN
  logic [CNTW-1:0] r_cnt;

  // Saturating count of cycles with any mismatch; clr takes priority.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_any && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign errCnt = r_cnt;
`else
  logic w_unused_any;
  assign w_unused_any = w_any;
  assign errCnt       = '0;
`endif

endmodule

// File: tb/tb_tmr_replica_monitor.sv
// Directed testbench for tmr_replica_monitor. A second instance with CNTW=2 exercises
// counter saturation. Counter expectations follow TMR_MONITOR_ERRCNT_EN.
module tb_tmr_replica_monitor;

`ifdef TMR_MONITOR_ERRCNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic [7:0] inA, inB, inC;
  logic       clr;
  logic [7:0] out;
  logic       misA, misB, misC, multi;
  logic [1:0] state, faultId;
  logic [15:0] errCnt;

  logic [7:0] s_out;
  logic       s_misA, s_misB, s_misC, s_multi;
  logic [1:0] s_state, s_faultId;
  logic [1:0] s_errCnt;

  int n_checks = 0;
  int n_errors = 0;

  tmr_replica_monitor #(.W(8), .PERSIST(3), .CNTW(16)) u_dut (
    .clk(clk), .rstn(rstn), .inA(inA), .inB(inB), .inC(inC), .clr(clr),
    .out(out), .misA(misA), .misB(misB), .misC(misC), .multi(multi),
    .state(state), .faultId(faultId), .errCnt(errCnt)
  );

  tmr_replica_monitor #(.W(8), .PERSIST(3), .CNTW(2)) u_sat (
    .clk(clk), .rstn(rstn), .inA(inA), .inB(inB), .inC(inC), .clr(clr),
    .out(s_out), .misA(s_misA), .misB(s_misB), .misC(s_misC), .multi(s_multi),
    .state(s_state), .faultId(s_faultId), .errCnt(s_errCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    inA = a;
    inB = b;
    inC = c;
  endtask

  function automatic logic [31:0] cnt(input int v);
    return CntEn ? v : 0;
  endfunction

  initial begin
    rstn = 1'b0;
    clr  = 1'b0;
    drive(8'h00, 8'h00, 8'h00);
    step();
    step();
    check_eq("rst_out", out, 8'h00);
    check_eq("rst_mis", {misA, misB, misC}, 3'b000);
    check_eq("rst_multi", multi, 1'b0);
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_fid", faultId, 2'd0);
    check_eq("rst_cnt", errCnt, 16'd0);

    // All replicas agree.
    rstn = 1'b1;
    drive(8'h5A, 8'h5A, 8'h5A);
    repeat (4) step();
    check_eq("agree_out", out, 8'h5A);
    check_eq("agree_mis", {misA, misB, misC}, 3'b000);
    check_eq("agree_state", state, 2'd0);
    check_eq("agree_cnt", errCnt, 16'd0);

    // B persistently wrong for PERSIST cycles -> FAULT on B.
    drive(8'h3C, 8'h00, 8'h3C);
    step();
    check_eq("b1_out", out, 8'h3C);
    check_eq("b1_mis", {misA, misB, misC}, 3'b010);
    check_eq("b1_state", state, 2'd1);
    step();
    check_eq("b2_state", state, 2'd1);
    check_eq("b2_fid", faultId, 2'd0);
    step();
    check_eq("b3_state", state, 2'd2);
    check_eq("b3_fid", faultId, 2'd2);
    check_eq("b3_cnt", errCnt, cnt(3));

    // FAULT holds while voting continues.
    drive(8'h5A, 8'h5A, 8'h5A);
    step();
    check_eq("hold_state", state, 2'd2);
    check_eq("hold_fid", faultId, 2'd2);
    check_eq("hold_mis", {misA, misB, misC}, 3'b000);
    check_eq("hold_cnt", errCnt, cnt(3));

    // clr with a simultaneous A mismatch: clr wins, misA still reported.
    drive(8'hFF, 8'h11, 8'h11);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clr_state", state, 2'd0);
    check_eq("clr_fid", faultId, 2'd0);
    check_eq("clr_cnt", errCnt, 16'd0);
    check_eq("clr_misA", misA, 1'b1);
    check_eq("clr_out", out, 8'h11);

    // C wrong twice, then A wrong twice: suspect id switches, no FAULT.
    drive(8'h22, 8'h22, 8'h22);
    step();
    check_eq("sw_ok", state, 2'd0);
    drive(8'h22, 8'h22, 8'h99);
    step();
    check_eq("sw_c1", state, 2'd1);
    step();
    check_eq("sw_c2", state, 2'd1);
    check_eq("sw_c2_mis", {misA, misB, misC}, 3'b001);
    drive(8'h99, 8'h22, 8'h22);
    step();
    check_eq("sw_a1", state, 2'd1);
    step();
    check_eq("sw_a2", state, 2'd1);
    check_eq("sw_a2_mis", {misA, misB, misC}, 3'b100);
    drive(8'h22, 8'h22, 8'h22);
    step();
    check_eq("sw_back", state, 2'd0);
    check_eq("sw_fid", faultId, 2'd0);
    check_eq("sw_cnt", errCnt, cnt(4));

    // All three pairwise different -> immediate multi-fault.
    drive(8'h01, 8'h02, 8'h04);
    step();
    check_eq("mf_out", out, 8'h00);
    check_eq("mf_multi", multi, 1'b1);
    check_eq("mf_state", state, 2'd2);
    check_eq("mf_fid", faultId, 2'd3);
    check_eq("mf_mis", {misA, misB, misC}, 3'b111);
    check_eq("mf_cnt", errCnt, cnt(5));
    drive(8'h22, 8'h22, 8'h22);
    step();
    check_eq("mf_sticky", multi, 1'b1);
    check_eq("mf_hold", faultId, 2'd3);

    // Reset mid-FAULT discards history; next edge is evaluated fresh.
    rstn = 1'b0;
    step();
    check_eq("rr_state", state, 2'd0);
    check_eq("rr_multi", multi, 1'b0);
    check_eq("rr_cnt", errCnt, 16'd0);
    rstn = 1'b1;
    drive(8'h22, 8'h77, 8'h22);
    step();
    check_eq("rr_fresh", state, 2'd1);
    check_eq("rr_fresh_cnt", errCnt, cnt(1));

    // Saturation on the CNTW=2 instance: counts 1,2,3 then holds at 3.
    clr = 1'b1;
    drive(8'h22, 8'h22, 8'h22);
    step();
    clr = 1'b0;
    check_eq("sat_clr", s_errCnt, 2'd0);
    drive(8'h22, 8'h22, 8'h66);
    step();
    step();
    check_eq("sat_2", s_errCnt, 2'(cnt(2)));
    step();
    check_eq("sat_3", s_errCnt, 2'(cnt(3)));
    step();
    step();
    check_eq("sat_hold", s_errCnt, 2'(cnt(3)));
    check_eq("sat_main", errCnt, cnt(5));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/tmr_replica_monitor.md
TMR_REPLICA_MONITOR -- requirements
Module: tmr_replica_monitor

Interface
REQ-001 The block SHALL have parameter W, default 8: width of each replica word.
REQ-002 The block SHALL have parameter PERSIST, default 3: consecutive mismatch cycles before a replica is declared faulty; legal range 2..15.
REQ-003 The block SHALL have parameter CNTW, default 16: width of the mismatch-cycle counter.
REQ-004 The block SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-006 The block SHALL have ports inA, inB, inC, input, W each: the three replica words from the upstream triplicated FSM.
REQ-007 The block SHALL have port clr, input, 1: single-cycle clear of fault state and counter.
REQ-008 The block SHALL have port out, output, W: the registered bitwise majority of inA/inB/inC.
REQ-009 The block SHALL have ports misA, misB, misC, output, 1 each: registered per-replica mismatch flags.
REQ-010 The block SHALL have port multi, output, 1: registered flag, set when all three words are pairwise different.
REQ-011 The block SHALL have port state, output, 2: FSM state, encoded OK=0, SUSPECT=1, FAULT=2.
REQ-012 The block SHALL have port faultId, output, 2: faulty replica, encoded none=0, A=1, B=2, C=3; multi-fault is also 3 with multi sticky.
REQ-013 The block SHALL have port errCnt, output, CNTW: saturating count of mismatch cycles.

Function
REQ-014 Voting: at each edge, out <= bitwise (inA&inB)|(inB&inC)|(inA&inC); latency 1 cycle.
REQ-015 Mismatch flags: at the same edge, misX <= (inX != voted word); at most one misX is set unless multi.
REQ-016 Single mismatch: exactly one misX is set and multi is 0.
REQ-017 The per-replica suspect counter pc and the suspect id sid SHALL be internal registers.
REQ-018 OK state: on a single mismatch of X, go to SUSPECT with sid=X and pc=1; otherwise stay in OK with pc=0.
REQ-019 SUSPECT, same X mismatching: pc increments; when the new value equals PERSIST, go to FAULT with faultId=X.
REQ-020 SUSPECT, different replica Y mismatching: stay in SUSPECT with sid=Y and pc=1.
REQ-021 SUSPECT, no mismatch: return to OK with pc=0.
REQ-022 Multi condition in OK or SUSPECT: go to FAULT immediately, faultId=3, multi held at 1 until clr.
REQ-023 FAULT: hold state and faultId regardless of inputs; voting and misX continue to update.
REQ-024 clr: go to OK, with pc=0, sid=0, faultId=0, multi=0 and errCnt=0.
REQ-025 clr has priority over any simultaneous mismatch; that cycle's mismatch is not counted and does not advance the FSM.
REQ-026 errCnt increments by 1 on each edge where any mismatch or multi is detected; it saturates at 2^CNTW-1 and never wraps.

Reset
REQ-027 When rstn=0 at an edge, out=0, misA/B/C=0, multi=0, state=OK, faultId=0, pc=0, sid=0 and errCnt=0.
REQ-028 Reset mid-SUSPECT or mid-FAULT SHALL discard all history; the first post-reset edge evaluates the inputs fresh.

Configuration
REQ-029 With macro TMR_MONITOR_ERRCNT_EN defined, the errCnt counter SHALL be implemented per REQ-026.
REQ-030 Without TMR_MONITOR_ERRCNT_EN, errCnt SHALL be constant 0, no counter flops are inferred, and all other behaviour is unchanged.

Verification (W=8, PERSIST=3, CNTW=16, macro defined)
REQ-031 Reset, then inA=inB=inC=8'h5A for 4 cycles -> out=8'h5A one cycle later, no misX, state=OK, errCnt=0.
REQ-032 inB=8'h00, inA=inC=8'h3C for 3 consecutive cycles -> out=8'h3C, misB=1, state SUSPECT(pc1), SUSPECT(pc2), then FAULT with faultId=2 and errCnt=3.
REQ-033 inC differs for 2 cycles, then inA differs for 2 cycles, then all agree -> state stays SUSPECT with sid changing C then A, then returns to OK, errCnt=4, no FAULT.
REQ-034 inA=8'h01, inB=8'h02, inC=8'h04 for 1 cycle -> out=8'h00, multi=1, state=FAULT, faultId=3.
REQ-035 In FAULT, pulse clr together with an inA mismatch -> state=OK, faultId=0, errCnt=0, with misA still reported for that cycle.
REQ-036 Force errCnt to 16'hFFFE and run 3 mismatch cycles -> errCnt=16'hFFFF and holds; build without the macro -> errCnt=0 throughout.
